// File: rtl/detect_pkg.sv
// Shared types and constants for the detection counter: BCD digit limits,
// LED stretch FSM states and active-low 7-segment patterns (a..g in bits 0..6).
package detect_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stretch_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decode one BCD digit to active-low segments; non-BCD codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/detect_counter_bcd_digit.sv
// One decade of the BCD detection counter. carry_out is combinational so a
// whole chain of digits ripples within a single cycle.
module bcd_digit
  import detect_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic             carry_out,
  output logic [BCD_W-1:0] digit
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  assign carry_out = inc & (digit_q == BCD_MAX);
  assign digit     = digit_q;

  // Next digit value: clear wins, otherwise count 0..9 and wrap to 0.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      if (digit_q == BCD_MAX) begin
        digit_d = 4'd0;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/detect_counter.sv
// Detection counter: rising-edge detect of z, DIGITS-wide BCD count with
// sticky overflow, and a pulse-stretched LED.
// Optional multiplexed 7-segment display when DETECT_COUNTER_SEG_EN is defined.
module detect_counter
  import detect_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int STRETCH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  z,
  input  logic                  clear,
  output logic                  z_rise,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  overflow,
  output logic                  led
`ifdef DETECT_COUNTER_SEG_EN
  ,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
`endif
);

  localparam int               CNT_W  = $clog2(STRETCH) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH - 1);

  logic                 z_d1_q;
  logic                 z_rise_q;
  logic                 overflow_q;
  logic                 overflow_d;
  logic                 rise_s;
  logic [DIGITS:0]      carry_s;
  stretch_state_e       state_q;
  stretch_state_e       state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  assign rise_s     = z & ~z_d1_q;
  assign carry_s[0] = rise_s;

  // BCD digit chain; the carry out of the last digit marks a full wrap.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .inc       (carry_s[k]),
      .carry_out (carry_s[k+1]),
      .digit     (count_bcd[4*k +: 4])
    );
  end

  // Sticky overflow: cleared by clear, set by a wrap from all nines.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (carry_s[DIGITS]) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Edge-detect history, rise pulse and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_d1_q     <= 1'b0;
      z_rise_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      z_d1_q     <= z;
      z_rise_q   <= rise_s;
      overflow_q <= overflow_d;
    end
  end

  // Stretch FSM next state: each detection (re)loads the hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = HOLD;
          cnt_d   = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (rise_s) begin
          cnt_d = RELOAD;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stretch FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z_rise   = z_rise_q;
  assign overflow = overflow_q;
  assign led      = (state_q == HOLD);

`ifdef DETECT_COUNTER_SEG_EN
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [15:0]       refresh_q;
  logic [SEL_W-1:0]  sel_s;
  logic [3:0]        digit_sel_s;
  logic [DIGITS-1:0] an_d;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;

  if (DIGITS > 1) begin : g_sel_multi
    assign sel_s = refresh_q[15 -: SEL_W];
  end else begin : g_sel_single
    assign sel_s = {SEL_W{1'b0}};
  end

  // Pick the digit addressed by the refresh counter and its anode.
  always_comb begin
    digit_sel_s = 4'hF;
    an_d        = {DIGITS{1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      if (sel_s == SEL_W'(k)) begin
        digit_sel_s = count_bcd[4*k +: 4];
        an_d[k]     = 1'b0;
      end else begin
        an_d[k]     = 1'b1;
      end
    end
  end

  // Refresh counter and registered display drive; blank after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= 16'd0;
      an_q      <= {DIGITS{1'b1}};
      seg_q     <= SEG_BLANK;
    end else begin
      refresh_q <= refresh_q + 16'd1;
      an_q      <= an_d;
      seg_q     <= bcd_to_seg(digit_sel_s);
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
`endif

endmodule
